cs_adder_pipe: RTL
==================

CS_ADDER_PIPE -- requirements
Module: cs_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and sum width in bits.
REQ-002 SHALL have parameter BLOCK, default 4, meaning the width of one carry-select block (a zero-carry and a one-carry ripple sum, muxed).
REQ-003 SHALL have parameter BLK_PER_STG, default 2, meaning the number of carry-select blocks resolved per pipeline stage.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-008 SHALL have port A, input, WIDTH bits: the first operand.
REQ-009 SHALL have port B, input, WIDTH bits: the second operand.
REQ-010 SHALL have port Carry_i, input, 1 bit: the carry-in, used for addition only.
REQ-011 SHALL have port sub, input, 1 bit: 1 selects A-B, 0 selects A+B+Carry_i.
REQ-012 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port S, output, WIDTH bits: the sum or difference.
REQ-015 SHALL have port Carry_o, output, 1 bit: the carry-out of the MSB (for subtraction, 1 = no borrow).
REQ-016 SHALL have port Ovf, output, 1 bit: the two's-complement signed overflow flag.

Function
REQ-017 SHALL reject elaboration unless WIDTH is divisible by BLOCK*BLK_PER_STG; pipeline depth L = WIDTH/(BLOCK*BLK_PER_STG).
REQ-018 SHALL accept an operation on a cycle where in_valid and in_ready are both 1.
REQ-019 SHALL treat subtraction as A + ~B + 1; Carry_i is ignored when sub=1.
REQ-020 SHALL have stage k resolve bits [(k+1)*BLOCK*BLK_PER_STG-1 : k*BLOCK*BLK_PER_STG]:
- each block computes both carry-0 and carry-1 sums;
- each block selects between them with the carry from the block below.
REQ-021 SHALL have each stage register its valid bit, the resolved low sum bits, the stage carry, and the still-unprocessed operand bits and mode.
REQ-022 SHALL assert out_valid exactly L cycles after acceptance when there is no stall; throughput is 1 operation per cycle.
REQ-023 SHALL implement stall as follows:
- stall = out_valid AND NOT out_ready;
- during a stall all stage registers hold;
- in_ready = NOT stall.
REQ-024 SHALL let a bubble (invalid stage) advance normally and never produce out_valid.
REQ-025 SHALL keep results in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-026 SHALL hold S, Carry_o and Ovf stable while out_valid=1 and out_ready=0.
REQ-027 SHALL compute S as modulo 2^WIDTH, and Carry_o as bit WIDTH of the full-width sum.
REQ-028 SHALL compute Ovf = carry into MSB XOR carry out of MSB.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear all stage valid bits, so out_valid=0 and in_ready=1 on the next cycle.
REQ-030 SHALL reset S, Carry_o and Ovf to 0.
REQ-031 SHALL discard in-flight operations when rst is asserted mid-operation; they never appear at the output.
REQ-032 SHALL ignore in_valid on a cycle where rst=1.

Configuration
REQ-033 SHALL use macro CS_ADDER_PIPE_OVF_EN to control overflow-detection logic:
- defined: Ovf is computed per REQ-028 and pipelined alongside S;
- undefined: Ovf is tied to 0 and no overflow logic or registers exist.

Verification (WIDTH=32, BLOCK=4, BLK_PER_STG=2, L=4)
REQ-034 SHALL cover: A=0xFFFFFFFF, B=0x00000001, Carry_i=0, sub=0 -> 4 cycles later out_valid=1, S=0x00000000, Carry_o=1, Ovf=0.
REQ-035 SHALL cover: A=5, B=7, sub=1 -> S=0xFFFFFFFE, Carry_o=0, Ovf=0.
REQ-036 SHALL cover: A=0x7FFFFFFF, B=1, sub=0 -> S=0x80000000, Carry_o=0, Ovf=1 with the macro defined and Ovf=0 without it.
REQ-037 SHALL cover back-pressure:
- stimulus: 8 back-to-back operations (A=i, B=i, i=0..7); out_ready low for cycles 5-9, then high;
- required: in_ready=0 exactly during the stall; S=0,2,4,...,14 in order; no drops.
REQ-038 SHALL cover reset mid-flight: rst pulsed 1 cycle after 3 accepts -> out_valid stays 0 thereafter; a new operation A=1, B=2 yields S=3 after 4 cycles.

Source files
------------

// File: rtl/cs_adder_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Define CS_ADDER_PIPE_OVF_EN to build the signed-overflow flag.
module cs_adder_pipe #(
    parameter int WIDTH       = 32,
    parameter int BLOCK       = 4,
    parameter int BLK_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_i,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Carry_o,
    output logic             Ovf
);

    localparam int SEG = BLOCK * BLK_PER_STG;
    localparam int L   = WIDTH / SEG;

    if (BLOCK < 1 || BLK_PER_STG < 1 || (WIDTH % SEG) != 0 || L < 1) begin : g_bad_cfg
        $error("cs_adder_pipe: WIDTH must be a multiple of BLOCK*BLK_PER_STG");
    end

    logic             v_q [L];
    logic [WIDTH-1:0] s_q [L];
    logic [WIDTH-1:0] a_q [L];
    logic [WIDTH-1:0] b_q [L];
    logic             c_q [L];
    logic             m_q [L];

    logic             st_v [L];
    logic [WIDTH-1:0] st_a [L];
    logic [WIDTH-1:0] st_b [L];
    logic [WIDTH-1:0] st_s [L];
    logic             st_c [L];
    logic             st_m [L];

    logic [SEG-1:0]   seg_n [L];
    logic [WIDTH-1:0] s_n   [L];
    logic             co_n  [L];

    logic [SEG-1:0]   bb;
    logic             cc;
    logic [BLOCK:0]   z_sum;
    logic [BLOCK:0]   o_sum;
    logic [BLOCK:0]   sel;

    logic stall;

    assign stall     = v_q[L-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[L-1];
    assign S         = s_q[L-1];
    assign Carry_o   = c_q[L-1];

    // Stage 0 works on the ports; later stages on the previous register.
    always_comb begin
        st_v[0] = in_valid;
        st_a[0] = A;
        st_b[0] = B;
        st_s[0] = '0;
        st_c[0] = sub | Carry_i;
        st_m[0] = sub;
        for (int k = 1; k < L; k++) begin
            st_v[k] = v_q[k-1];
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
            st_m[k] = m_q[k-1];
        end
    end

    // Each block forms carry-0 and carry-1 sums, then the incoming carry picks one.
    always_comb begin
        bb    = '0;
        cc    = 1'b0;
        z_sum = '0;
        o_sum = '0;
        sel   = '0;
        for (int k = 0; k < L; k++) begin
            seg_n[k] = '0;
            bb = st_m[k] ? ~st_b[k][SEG-1:0] : st_b[k][SEG-1:0];
            cc = st_c[k];
            for (int j = 0; j < BLK_PER_STG; j++) begin
                z_sum = {1'b0, st_a[k][j*BLOCK +: BLOCK]} + {1'b0, bb[j*BLOCK +: BLOCK]};
                o_sum = z_sum + (BLOCK+1)'(1);
                sel   = cc ? o_sum : z_sum;
                seg_n[k][j*BLOCK +: BLOCK] = sel[BLOCK-1:0];
                cc = sel[BLOCK];
            end
            co_n[k] = cc;
            s_n[k]  = (st_s[k] >> SEG) | (WIDTH'(seg_n[k]) << (WIDTH - SEG));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                v_q[k] <= 1'b0;
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
                m_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < L; k++) begin
                v_q[k] <= st_v[k];
                if (st_v[k]) begin
                    s_q[k] <= s_n[k];
                    a_q[k] <= st_a[k] >> SEG;
                    b_q[k] <= st_b[k] >> SEG;
                    c_q[k] <= co_n[k];
                    m_q[k] <= st_m[k];
                end
            end
        end
    end

`ifdef CS_ADDER_PIPE_OVF_EN
    logic b_top;
    logic ovf_n;
    logic ovf_q;

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    assign b_top = st_m[L-1] ? ~st_b[L-1][SEG-1] : st_b[L-1][SEG-1];
    assign ovf_n = co_n[L-1] ^ st_a[L-1][SEG-1] ^ b_top ^ seg_n[L-1][SEG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall && st_v[L-1]) begin
            ovf_q <= ovf_n;
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

endmodule
